alu_rs_pool: RTL and testbench
==============================

Name: alu_rs_pool

Overview:
- Parametrised ALU reservation station and execute stage.
- Holds up to ENTRIES issued ALU ops and wakes their operands from NUM_CDB common-data-bus broadcasts.
- Each cycle it selects the oldest ready op, computes it, and presents the result on a registered CDB output with a valid/ready handshake to the CDB arbiter.
- Sits between Decoder (issue) and CDB arbiter; supports pipeline flush.

Parameters:
ENTRIES, 8, station depth (>=2)
DATA_W, 32, operand/result width
LOCK_W, 4, rename tag width
NO_LOCK, 0, tag value meaning "operand available"
NUM_CDB, 2, number of CDB broadcast inputs
OP_W, 5, opcode width (codes per defines.v)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  squash all held ops and output
issue_valid  in  1  Decoder presents op
issue_ready  out  1  station can accept op
issue_op  in  OP_W  opcode
issue_rd_lock  in  LOCK_W  destination tag
issue_lock1  in  LOCK_W  src1 tag, NO_LOCK = ready
issue_data1  in  DATA_W  src1 value when ready
issue_lock2  in  LOCK_W  src2 tag
issue_data2  in  DATA_W  src2 value
cdb_in_valid  in  NUM_CDB  per-bus broadcast valid
cdb_in_index  in  NUM_CDB*LOCK_W  packed tags, bus k at [k*LOCK_W +: LOCK_W]
cdb_in_result  in  NUM_CDB*DATA_W  packed results
cdb_out_valid  out  1  result valid
cdb_out_ready  in  1  arbiter accepts result
cdb_out_index  out  LOCK_W  result tag
cdb_out_result  out  DATA_W  result value

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous, active-high.
- Reset: all entries invalid; cdb_out_valid=0, cdb_out_index=NO_LOCK, cdb_out_result=0; issue_ready=1 the cycle after. Reset mid-operation discards everything, with no partial output.
- Storage: collapsing queue; entry 0 = oldest. Per entry: valid, op, rd_lock, lock1/data1, lock2/data2.
- Issue:
  - issue_ready = (count < ENTRIES), from registered state only.
  - Accepted when issue_valid && issue_ready && !flush.
  - Written at the lowest free slot after the current cycle's removal has collapsed the queue.
  - Full + removal same cycle: issue_ready still 0, no accept.
- Wakeup:
  - For every valid entry and each operand with lock != NO_LOCK: if cdb_in_valid[k] && cdb_in_index[k] == lock, set data = result[k] and lock = NO_LOCK at the edge.
  - Same check applies to the op being issued in that cycle (issue-cycle bypass).
  - Multiple matching buses: lowest k wins.
  - Broadcasts with index == NO_LOCK are ignored.
- Ready: valid && lock1 == NO_LOCK && lock2 == NO_LOCK, evaluated on registered state. An entry woken at edge E is selectable in the cycle after E.
- Select/execute:
  - Output register free = !cdb_out_valid || cdb_out_ready.
  - When free and any entry is ready: lowest-index ready entry is removed and the queue collapses.
  - Output register loads cdb_out_valid=1, index=rd_lock, result=f(op).
  - When free and none is ready: cdb_out_valid <= 0.
  - While cdb_out_valid && !cdb_out_ready: output held stable, no selection.
- Latency: op issued with ready operands at edge E0 appears on cdb_out_valid after edge E0+1. Throughput: 1 result/cycle with ready held high.
- Ops (DATA_W-bit, wrap on overflow):
  - ADD/JAL/AUIPC: a+b; SUB: a-b.
  - SLT: signed a<b ? 1 : 0; SLTU: unsigned compare.
  - XOR/OR/AND: bitwise.
  - SLL/SRL: logical shift by b[log2(DATA_W)-1:0]; SRA: arithmetic shift.
  - JALR: (a+b) & ~1.
  - Undefined/NOP op: result 0, still retired with its tag.
- Flush: at the edge with flush=1, all entries invalid, cdb_out_valid=0, and the issue in that cycle is dropped. Flush has priority over issue, wakeup and select; rst has priority over flush.

Optional Feature:
ALU_RS_PERF_EN:
- Defined: adds outputs perf_full_cycles (32) and perf_retired (32).
  - perf_full_cycles increments each cycle issue_valid && !issue_ready.
  - perf_retired increments on each cdb_out_valid && cdb_out_ready.
  - Both wrap, are cleared by rst, and are not cleared by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Issue ADD data1=5, data2=7, both NO_LOCK, rd_lock=3, ready=1 -> cdb_out_valid after 2nd edge with index=3, result=12, then 0.
- Issue SUB lock1=2 (older), then OR ready ops; broadcast tag 2 = 100 on bus 1 two cycles later -> OR retires first, then SUB result 100-data2. Older-first order holds among ready ops.
- Fill ENTRIES ops all waiting on tag 5 -> issue_ready=0. Broadcast tag 5 = 1 -> ops retire oldest first at 1/cycle; issue_ready returns 1 one cycle after first removal.
- Hold cdb_out_ready=0 for 4 cycles with ready ops queued -> output value/index stable, no entry lost. Release -> results in issue order.
- Issue op with lock2=6 in the same cycle bus 0 broadcasts tag 6 = 0xFFFF_FFFF as SRA shift source -> captured; SRA 0x8000_0000 by 31 yields 0xFFFF_FFFF. Then flush with 3 queued plus valid output -> next cycle cdb_out_valid=0, issue_ready=1, nothing retires.

Source files
------------

// File: rtl/alu_rs_pool.sv
// ALU reservation station: collapsing oldest-first queue, CDB wakeup, one-op-per-cycle execute into a registered CDB output.
// Optional performance counters are compiled in when ALU_RS_PERF_EN is defined.
module alu_rs_pool #(
  parameter int ENTRIES = 8,
  parameter int DATA_W  = 32,
  parameter int LOCK_W  = 4,
  parameter int NO_LOCK = 0,
  parameter int NUM_CDB = 2,
  parameter int OP_W    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [OP_W-1:0]            issue_op,
  input  logic [LOCK_W-1:0]          issue_rd_lock,
  input  logic [LOCK_W-1:0]          issue_lock1,
  input  logic [DATA_W-1:0]          issue_data1,
  input  logic [LOCK_W-1:0]          issue_lock2,
  input  logic [DATA_W-1:0]          issue_data2,
  input  logic [NUM_CDB-1:0]         cdb_in_valid,
  input  logic [NUM_CDB*LOCK_W-1:0]  cdb_in_index,
  input  logic [NUM_CDB*DATA_W-1:0]  cdb_in_result,
  output logic                       cdb_out_valid,
  input  logic                       cdb_out_ready,
  output logic [LOCK_W-1:0]          cdb_out_index,
  output logic [DATA_W-1:0]          cdb_out_result
`ifdef ALU_RS_PERF_EN
  ,
  output logic [31:0]                perf_full_cycles,
  output logic [31:0]                perf_retired
`endif
);

  localparam logic [LOCK_W-1:0] NL = LOCK_W'(NO_LOCK);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(ENTRIES + 1);

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(13);

  function automatic logic [DATA_W-1:0] alu(input logic [OP_W-1:0] op,
                                            input logic signed [DATA_W-1:0] a,
                                            input logic signed [DATA_W-1:0] b);
    logic [SH_W-1:0] sh;
    sh = b[SH_W-1:0];
    case (op)
      OP_ADD, OP_JAL, OP_AUIPC: return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return {{(DATA_W-1){1'b0}}, (a < b)};
      OP_SLTU: return {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_SLL:  return $unsigned(a) << sh;
      OP_SRL:  return $unsigned(a) >> sh;
      OP_SRA:  return a >>> sh;
      OP_JALR: return (a + b) & ~DATA_W'(1);
      default: return '0;
    endcase
  endfunction

  // Returns {lock, data}; lowest-numbered matching bus wins, NO_LOCK broadcasts never match.
  function automatic logic [LOCK_W+DATA_W-1:0] wake(input logic [LOCK_W-1:0]         lk,
                                                    input logic [DATA_W-1:0]         dt,
                                                    input logic [NUM_CDB-1:0]        cv,
                                                    input logic [NUM_CDB*LOCK_W-1:0] ci,
                                                    input logic [NUM_CDB*DATA_W-1:0] cr);
    logic [LOCK_W-1:0] l;
    logic [DATA_W-1:0] d;
    l = lk;
    d = dt;
    if (lk != NL) begin
      for (int k = NUM_CDB-1; k >= 0; k--) begin
        if (cv[k] && ci[k*LOCK_W +: LOCK_W] == lk) begin
          l = NL;
          d = cr[k*DATA_W +: DATA_W];
        end
      end
    end
    return {l, d};
  endfunction

  logic [ENTRIES-1:0] vld_p0;
  logic [OP_W-1:0]    op_p0 [ENTRIES];
  logic [LOCK_W-1:0]  rd_p0 [ENTRIES];
  logic [LOCK_W-1:0]  l1_p0 [ENTRIES];
  logic [DATA_W-1:0]  d1_p0 [ENTRIES];
  logic [LOCK_W-1:0]  l2_p0 [ENTRIES];
  logic [DATA_W-1:0]  d2_p0 [ENTRIES];

  logic               vld_p1;
  logic [LOCK_W-1:0]  idx_p1;
  logic [DATA_W-1:0]  res_p1;

  logic [ENTRIES-1:0] v_nxt;
  logic [OP_W-1:0]    op_nxt [ENTRIES];
  logic [LOCK_W-1:0]  rd_nxt [ENTRIES];
  logic [LOCK_W-1:0]  l1_nxt [ENTRIES];
  logic [DATA_W-1:0]  d1_nxt [ENTRIES];
  logic [LOCK_W-1:0]  l2_nxt [ENTRIES];
  logic [DATA_W-1:0]  d2_nxt [ENTRIES];

  logic [LOCK_W-1:0]  wl1 [ENTRIES];
  logic [DATA_W-1:0]  wd1 [ENTRIES];
  logic [LOCK_W-1:0]  wl2 [ENTRIES];
  logic [DATA_W-1:0]  wd2 [ENTRIES];
  logic [LOCK_W-1:0]  il1, il2;
  logic [DATA_W-1:0]  id1, id2;

  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   slot;
  int                 sel;
  int                 src;
  logic               sel_any, out_free, rem, accept;

  always_comb begin
    count = '0;
    for (int i = 0; i < ENTRIES; i++) count = count + CNT_W'(vld_p0[i]);
  end

  assign issue_ready    = (count < CNT_W'(ENTRIES));
  assign cdb_out_valid  = vld_p1;
  assign cdb_out_index  = idx_p1;
  assign cdb_out_result = res_p1;

  always_comb begin
    out_free = !vld_p1 || cdb_out_ready;
    sel      = 0;
    sel_any  = 1'b0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (vld_p0[i] && l1_p0[i] == NL && l2_p0[i] == NL) begin
        sel     = i;
        sel_any = 1'b1;
      end
    end
    rem    = out_free && sel_any;
    accept = issue_valid && issue_ready && !flush;
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      {wl1[i], wd1[i]} = wake(l1_p0[i], d1_p0[i], cdb_in_valid, cdb_in_index, cdb_in_result);
      {wl2[i], wd2[i]} = wake(l2_p0[i], d2_p0[i], cdb_in_valid, cdb_in_index, cdb_in_result);
    end
  end

  // Collapse past the removed entry, then append the incoming op at the first free slot.
  always_comb begin
    slot       = count - CNT_W'(rem);
    {il1, id1} = wake(issue_lock1, issue_data1, cdb_in_valid, cdb_in_index, cdb_in_result);
    {il2, id2} = wake(issue_lock2, issue_data2, cdb_in_valid, cdb_in_index, cdb_in_result);
    src        = 0;
    for (int j = 0; j < ENTRIES; j++) begin
      src = (rem && j >= sel) ? j + 1 : j;
      if (src >= ENTRIES) begin
        src      = j;
        v_nxt[j] = 1'b0;
      end else begin
        v_nxt[j] = vld_p0[src];
      end
      op_nxt[j] = op_p0[src];
      rd_nxt[j] = rd_p0[src];
      l1_nxt[j] = wl1[src];
      d1_nxt[j] = wd1[src];
      l2_nxt[j] = wl2[src];
      d2_nxt[j] = wd2[src];
      if (accept && CNT_W'(j) == slot) begin
        v_nxt[j]  = 1'b1;
        op_nxt[j] = issue_op;
        rd_nxt[j] = issue_rd_lock;
        l1_nxt[j] = il1;
        d1_nxt[j] = id1;
        l2_nxt[j] = il2;
        d2_nxt[j] = id2;
      end
    end
  end

  // p0: station storage
  always_ff @(posedge clk) begin
    if (rst || flush) vld_p0 <= '0;
    else              vld_p0 <= v_nxt;
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < ENTRIES; j++) begin
      op_p0[j] <= op_nxt[j];
      rd_p0[j] <= rd_nxt[j];
      l1_p0[j] <= l1_nxt[j];
      d1_p0[j] <= d1_nxt[j];
      l2_p0[j] <= l2_nxt[j];
      d2_p0[j] <= d2_nxt[j];
    end
  end

  // p1: registered CDB output
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      idx_p1 <= NL;
      res_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (out_free) begin
      vld_p1 <= sel_any;
      if (sel_any) begin
        idx_p1 <= rd_p0[sel];
        res_p1 <= alu(op_p0[sel], d1_p0[sel], d2_p0[sel]);
      end
    end
  end

`ifdef ALU_RS_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cycles <= '0;
      perf_retired     <= '0;
    end else begin
      if (issue_valid && !issue_ready) perf_full_cycles <= perf_full_cycles + 32'd1;
      if (vld_p1 && cdb_out_ready)     perf_retired     <= perf_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rs_pool.sv
// Bench for alu_rs_pool: directed scenarios plus randomized traffic checked every cycle against a queue-based model.
module tb_alu_rs_pool;

  localparam int ENTRIES = 8;

  logic        clk = 1'b0;
  logic        rst, flush, issue_valid, issue_ready;
  logic [4:0]  issue_op;
  logic [3:0]  issue_rd_lock, issue_lock1, issue_lock2;
  logic [31:0] issue_data1, issue_data2;
  logic [1:0]  cdb_in_valid;
  logic [7:0]  cdb_in_index;
  logic [63:0] cdb_in_result;
  logic        cdb_out_valid, cdb_out_ready;
  logic [3:0]  cdb_out_index;
  logic [31:0] cdb_out_result;
`ifdef ALU_RS_PERF_EN
  logic [31:0] perf_full_cycles, perf_retired;
`endif

  always #5 clk = ~clk;

  alu_rs_pool #(.ENTRIES(ENTRIES), .DATA_W(32), .LOCK_W(4), .NO_LOCK(0), .NUM_CDB(2), .OP_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rd_lock(issue_rd_lock), .issue_lock1(issue_lock1), .issue_data1(issue_data1),
    .issue_lock2(issue_lock2), .issue_data2(issue_data2),
    .cdb_in_valid(cdb_in_valid), .cdb_in_index(cdb_in_index), .cdb_in_result(cdb_in_result),
    .cdb_out_valid(cdb_out_valid), .cdb_out_ready(cdb_out_ready),
    .cdb_out_index(cdb_out_index), .cdb_out_result(cdb_out_result)
`ifdef ALU_RS_PERF_EN
    , .perf_full_cycles(perf_full_cycles), .perf_retired(perf_retired)
`endif
  );

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  rd, l1, l2;
    logic [31:0] d1, d2;
  } ent_t;

  ent_t        m_q[$];
  logic        m_ov;
  logic [3:0]  m_oidx;
  logic [31:0] m_ores;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  sh;
    logic [31:0] r;
    sh = b[4:0];
    case (op)
      5'd1, 5'd11, 5'd13: r = a + b;
      5'd2:  r = a - b;
      5'd3:  r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
      5'd4:  r = {31'b0, a < b};
      5'd5:  r = a ^ b;
      5'd6:  r = a | b;
      5'd7:  r = a & b;
      5'd8:  r = a << sh;
      5'd9:  r = a >> sh;
      5'd10: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      5'd12: r = (a + b) & 32'hFFFF_FFFE;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int bus_for(input logic [3:0] tag);
    int found;
    found = -1;
    if (tag != 4'd0)
      for (int k = 0; k < 2; k++)
        if (found < 0 && cdb_in_valid[k] && cdb_in_index[k*4 +: 4] == tag) found = k;
    return found;
  endfunction

  function automatic ent_t wake(input ent_t e);
    ent_t r;
    int   k;
    r = e;
    k = bus_for(e.l1);
    if (k >= 0) begin r.l1 = 4'd0; r.d1 = cdb_in_result[k*32 +: 32]; end
    k = bus_for(e.l2);
    if (k >= 0) begin r.l2 = 4'd0; r.d2 = cdb_in_result[k*32 +: 32]; end
    return r;
  endfunction

  function automatic void model_edge();
    bit   acc;
    int   s;
    ent_t e;
    acc = issue_valid && (m_q.size() < ENTRIES);
    if (rst) begin
      m_q.delete(); m_ov = 1'b0; m_oidx = 4'd0; m_ores = 32'd0;
      return;
    end
    if (flush) begin
      m_q.delete(); m_ov = 1'b0;
      return;
    end
    if (!m_ov || cdb_out_ready) begin
      s = -1;
      foreach (m_q[i]) if (s < 0 && m_q[i].l1 == 4'd0 && m_q[i].l2 == 4'd0) s = i;
      if (s >= 0) begin
        m_ov = 1'b1;
        m_oidx = m_q[s].rd;
        m_ores = ref_alu(m_q[s].op, m_q[s].d1, m_q[s].d2);
        m_q.delete(s);
      end else begin
        m_ov = 1'b0;
      end
    end
    foreach (m_q[i]) m_q[i] = wake(m_q[i]);
    if (acc) begin
      e.op = issue_op; e.rd = issue_rd_lock;
      e.l1 = issue_lock1; e.d1 = issue_data1;
      e.l2 = issue_lock2; e.d2 = issue_data2;
      m_q.push_back(wake(e));
    end
  endfunction

  task automatic step();
    @(negedge clk);
    chk("out_valid", cdb_out_valid, m_ov);
    chk("out_index", cdb_out_index, m_oidx);
    chk("out_result", cdb_out_result, m_ores);
    chk("issue_ready", issue_ready, m_q.size() < ENTRIES);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] op, input logic [3:0] rd,
                           input logic [3:0] l1, input logic [31:0] d1,
                           input logic [3:0] l2, input logic [31:0] d2);
    issue_valid = v; issue_op = op; issue_rd_lock = rd;
    issue_lock1 = l1; issue_data1 = d1; issue_lock2 = l2; issue_data2 = d2;
  endtask

  task automatic set_cdb(input int k, input logic v, input logic [3:0] t, input logic [31:0] r);
    cdb_in_valid[k] = v;
    cdb_in_index[k*4 +: 4] = t;
    cdb_in_result[k*32 +: 32] = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cdb_out_ready = 1'b1;
    set_issue(1'b0, 5'd0, 4'd0, 4'd0, 32'd0, 4'd0, 32'd0);
    cdb_in_valid = '0; cdb_in_index = '0; cdb_in_result = '0;
    repeat (2) @(posedge clk);
    #1;
    m_q.delete(); m_ov = 1'b0; m_oidx = 4'd0; m_ores = 32'd0;
    step();
    chk("rst_ready", issue_ready, 1'b1);
    chk("rst_index", cdb_out_index, 4'd0);
    rst = 1'b0;

    // ADD 5+7 -> tag 3 after the second edge
    set_issue(1'b1, 5'd1, 4'd3, 4'd0, 32'd5, 4'd0, 32'd7);
    step();
    issue_valid = 1'b0;
    step();
    chk("add_valid", cdb_out_valid, 1'b1);
    chk("add_index", cdb_out_index, 4'd3);
    chk("add_result", cdb_out_result, 32'd12);
    step();
    chk("add_done", cdb_out_valid, 1'b0);

    // Younger ready OR overtakes older waiting SUB
    set_issue(1'b1, 5'd2, 4'd4, 4'd2, 32'd0, 4'd0, 32'd30);
    step();
    set_issue(1'b1, 5'd6, 4'd5, 4'd0, 32'hF0, 4'd0, 32'h0F);
    step();
    issue_valid = 1'b0;
    step();
    set_cdb(1, 1'b1, 4'd2, 32'd100);
    step();
    cdb_in_valid = '0;
    idle(4);

    // Fill with ops waiting on tag 5, then release them
    for (int i = 0; i < ENTRIES; i++) begin
      set_issue(1'b1, 5'(i % 13 + 1), 4'(i + 1), 4'd5, 32'd0, 4'd0, 32'(i * 3 + 1));
      step();
    end
    set_issue(1'b1, 5'd1, 4'd15, 4'd0, 32'd40, 4'd0, 32'd2);
    step();
    chk("full_ready", issue_ready, 1'b0);
    step();
    set_cdb(0, 1'b1, 4'd5, 32'd1);
    step();
    cdb_in_valid = '0;
    step();
    issue_valid = 1'b0;
    idle(12);

    // Back-pressure for several cycles
    cdb_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_issue(1'b1, 5'($urandom_range(1, 13)), 4'(i + 9), 4'd0, $urandom, 4'd0, $urandom);
      step();
    end
    issue_valid = 1'b0;
    idle(3);
    cdb_out_ready = 1'b1;
    idle(7);

    flush = 1'b1;
    step();
    flush = 1'b0;

    // Issue-cycle bypass: bus 0 wins over bus 1 for the same tag
    set_issue(1'b1, 5'd10, 4'd7, 4'd0, 32'h8000_0000, 4'd6, 32'd0);
    set_cdb(0, 1'b1, 4'd6, 32'hFFFF_FFFF);
    set_cdb(1, 1'b1, 4'd6, 32'd3);
    step();
    cdb_in_valid = '0;
    issue_valid = 1'b0;
    step();
    chk("sra_valid", cdb_out_valid, 1'b1);
    chk("sra_index", cdb_out_index, 4'd7);
    chk("sra_result", cdb_out_result, 32'hFFFF_FFFF);

    // Flush with queued ops and a held output
    cdb_out_ready = 1'b0;
    set_issue(1'b1, 5'd1, 4'd8, 4'd0, 32'd1, 4'd0, 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      set_issue(1'b1, 5'd1, 4'(10 + i), 4'd9, 32'd0, 4'd0, 32'd1);
      step();
    end
    flush = 1'b1;
    set_issue(1'b1, 5'd1, 4'd14, 4'd0, 32'd2, 4'd0, 32'd2);
    step();
    flush = 1'b0;
    issue_valid = 1'b0;
    cdb_out_ready = 1'b1;
    chk("flush_valid", cdb_out_valid, 1'b0);
    chk("flush_ready", issue_ready, 1'b1);
    set_cdb(0, 1'b1, 4'd9, 32'd5);
    step();
    cdb_in_valid = '0;
    idle(3);

    // Randomized traffic with occasional flush and reset
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 39) == 0);
      cdb_out_ready = ($urandom_range(0, 3) != 0);
      set_issue($urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)), 4'($urandom_range(1, 15)),
                ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 7)), $urandom,
                ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 7)), $urandom);
      for (int k = 0; k < 2; k++)
        set_cdb(k, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 7)), $urandom);
      step();
    end
    rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; cdb_in_valid = '0; cdb_out_ready = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
